// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory bus between fetch stage (master) and instruction memory (slave)
// Ports: imem_req/imem_addr (master->slave request), imem_valid/imem_rdata (slave->master response)
interface fetch_stage_if;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  modport master(output imem_req, imem_addr, input imem_valid, imem_rdata);
  modport slave(input imem_req, imem_addr, output imem_valid, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches one instruction at a time and fills the IF/ID register
// Ports: clk, rst (async high); stall, redirect, redirect_pc from downstream; imem bus (master);
// IF/ID outputs instr_out, pc_out, pc_next_out, valid_out; halted once a HALT has been delivered
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [15:0]          redirect_pc,
  fetch_stage_if.master        imem,
  output logic [15:0]          instr_out,
  output logic [15:0]          pc_out,
  output logic [15:0]          pc_next_out,
  output logic                 valid_out,
  output logic                 halted
);
  typedef enum logic [1:0] {FETCH, WAIT, HOLD, HALTED} state_t;
  state_t state, state_d;
  logic [15:0] pc, pc_d, hold_buf, load_word;
  logic discard, discard_d, load, in_flight;
  // a request issued in a redirect cycle would be orphaned, so redirect suppresses it
  assign imem.imem_req  = state == FETCH && !rst && !redirect;
  assign imem.imem_addr = pc;
  assign in_flight      = state == WAIT && !imem.imem_valid;
  always_comb begin
    state_d   = state;
    pc_d      = pc;
    discard_d = discard;
    load      = 1'b0;
    load_word = hold_buf;
    if (redirect) begin
      pc_d      = redirect_pc & 16'hFFFE;
      state_d   = in_flight ? WAIT : FETCH;
      discard_d = in_flight;
    end else begin
      case (state)
        FETCH: state_d = WAIT;
        WAIT: if (imem.imem_valid) begin
          if (discard) begin
            discard_d = 1'b0;
            state_d   = FETCH;
          end else if (!stall) begin
            load      = 1'b1;
            load_word = imem.imem_rdata;
          end else
            state_d = HOLD;
        end
        HOLD: load = !stall;
        default: ;
      endcase
      if (load) begin
        pc_d    = pc + 16'd2;
        state_d = load_word[15:11] == 5'b00000 ? HALTED : FETCH;
      end
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      hold_buf    <= '0;
      discard     <= 1'b0;
      instr_out   <= NOP_INSTR;
      pc_out      <= '0;
      pc_next_out <= '0;
      valid_out   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      state   <= state_d;
      pc      <= pc_d;
      discard <= discard_d;
      // registered so halted follows the HALT word's appearance on instr_out by one cycle
      halted  <= state == HALTED && !redirect;
      if (state == WAIT && imem.imem_valid) hold_buf <= imem.imem_rdata;
      if (redirect || (!stall && !load)) begin
        instr_out <= NOP_INSTR;
        valid_out <= 1'b0;
      end else if (load) begin
        instr_out   <= load_word;
        pc_out      <= pc;
        pc_next_out <= pc + 16'd2;
        valid_out   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a latency-programmable instruction memory
module tb_fetch_stage;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] instr_out, pc_out, pc_next_out;
  logic valid_out, halted;
  fetch_stage_if bus();
  fetch_stage dut(.clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
                  .imem(bus.master), .instr_out(instr_out), .pc_out(pc_out), .pc_next_out(pc_next_out),
                  .valid_out(valid_out), .halted(halted));
  always #5 clk = ~clk;
  typedef struct {logic [15:0] pc; logic [15:0] instr;} exp_t;
  typedef struct {int due; logic [15:0] data;} rsp_t;
  exp_t sbq[$];
  rsp_t pend[$];
  logic [15:0] mem [logic [15:0]];
  int lat = 1, cyc = 0, tests = 0, fails = 0;
  logic last_v = 1'b0;
  logic [15:0] last_pc = 16'h0000;
  // unwritten locations read as HALT so every scenario stops fetching by itself
  function automatic logic [15:0] rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction
  always @(negedge clk) begin
    #1;
    cyc++;
    bus.imem_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      bus.imem_valid = 1'b1;
      bus.imem_rdata = pend[0].data;
      void'(pend.pop_front());
    end
    if (bus.imem_req) pend.push_back(rsp_t'{cyc + lat, rd(bus.imem_addr)});
  end
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (valid_out && (!last_v || pc_out != last_pc)) begin
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected: load pc=%h instr=%h, required no load", pc_out, instr_out);
      end else begin
        e = sbq.pop_front();
        if ({pc_out, instr_out, pc_next_out} !== {e.pc, e.instr, e.pc + 16'd2}) begin
          fails++;
          $display("FAIL sb_load: pc/instr/pc_next=%h/%h/%h, required %h/%h/%h",
                   pc_out, instr_out, pc_next_out, e.pc, e.instr, e.pc + 16'd2);
        end
      end
    end
    last_v  = valid_out;
    last_pc = pc_out;
  endtask
  task automatic expect_load(input logic [15:0] p, input logic [15:0] i);
    sbq.push_back(exp_t'{p, i});
  endtask
  task automatic start(input int l);
    rst = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    lat = l;
    mem.delete();
    tick();
    tick();
  endtask
  task automatic release_rst();
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
  endtask
  task automatic end_task(input string name);
    tests++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: %0d loads missing, required 0", name, sbq.size());
    end
    sbq.delete();
  endtask
  task automatic test_reset();
    tick();
    tick();
    tests++;
    if ({instr_out, pc_out, pc_next_out, valid_out, halted, bus.imem_req, bus.imem_addr} !==
        {16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL reset_state: instr/pc/pcn/v/h/req/addr=%h/%h/%h/%b/%b/%b/%h, required 0800/0000/0000/0/0/0/0000",
               instr_out, pc_out, pc_next_out, valid_out, halted, bus.imem_req, bus.imem_addr);
    end
  endtask
  task automatic test_basic();
    int n = 0;
    start(1);
    mem[16'h0000] = 16'h4001;
    mem[16'h0002] = 16'h4002;
    expect_load(16'h0000, 16'h4001);
    expect_load(16'h0002, 16'h4002);
    expect_load(16'h0004, 16'h0000);
    release_rst();
    tests++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL basic_c0: req/addr=%b/%h, required 1/0000", bus.imem_req, bus.imem_addr);
    end
    tick();
    tests++;
    if (bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL basic_c1: req=%b, required 0", bus.imem_req);
    end
    tick();
    tests++;
    if ({bus.imem_req, bus.imem_addr, instr_out, pc_out, pc_next_out, valid_out} !==
        {1'b1, 16'h0002, 16'h4001, 16'h0000, 16'h0002, 1'b1}) begin
      fails++;
      $display("FAIL basic_c2: req/addr/instr/pc/pcn/v=%b/%h/%h/%h/%h/%b, required 1/0002/4001/0000/0002/1",
               bus.imem_req, bus.imem_addr, instr_out, pc_out, pc_next_out, valid_out);
    end
    tick();
    tests++;
    if ({valid_out, instr_out} !== {1'b0, 16'h0800}) begin
      fails++;
      $display("FAIL basic_bubble: v/instr=%b/%h, required 0/0800", valid_out, instr_out);
    end
    tick();
    tests++;
    if ({bus.imem_req, bus.imem_addr, instr_out, pc_out} !== {1'b1, 16'h0004, 16'h4002, 16'h0002}) begin
      fails++;
      $display("FAIL basic_c4: req/addr/instr/pc=%b/%h/%h/%h, required 1/0004/4002/0002",
               bus.imem_req, bus.imem_addr, instr_out, pc_out);
    end
    tick();
    tick();
    tests++;
    if ({instr_out, valid_out, halted} !== {16'h0000, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL basic_halt_word: instr/v/h=%h/%b/%b, required 0000/1/0", instr_out, valid_out, halted);
    end
    tick();
    tests++;
    if ({halted, valid_out, instr_out} !== {1'b1, 1'b0, 16'h0800}) begin
      fails++;
      $display("FAIL basic_halted: h/v/instr=%b/%b/%h, required 1/0/0800", halted, valid_out, instr_out);
    end
    repeat (20) begin
      tick();
      if (bus.imem_req) n++;
    end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL basic_no_req_halted: %0d requests, required 0", n);
    end
    end_task("basic");
  endtask
  task automatic test_stall();
    int n = 0;
    start(1);
    mem[16'h0000] = 16'hD800;
    expect_load(16'h0000, 16'hD800);
    expect_load(16'h0002, 16'h0000);
    release_rst();
    tick();
    stall = 1'b1;
    repeat (3) begin
      tick();
      if (bus.imem_req) n++;
    end
    tests++;
    if ({n, valid_out} !== {32'd0, 1'b0}) begin
      fails++;
      $display("FAIL stall_hold: reqs/v=%0d/%b, required 0/0", n, valid_out);
    end
    stall = 1'b0;
    tick();
    tests++;
    if ({instr_out, pc_out, bus.imem_req, bus.imem_addr} !== {16'hD800, 16'h0000, 1'b1, 16'h0002}) begin
      fails++;
      $display("FAIL stall_release: instr/pc/req/addr=%h/%h/%b/%h, required D800/0000/1/0002",
               instr_out, pc_out, bus.imem_req, bus.imem_addr);
    end
    stall = 1'b1;
    tick();
    tick();
    tests++;
    if ({instr_out, valid_out, bus.imem_req} !== {16'hD800, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL stall_ifid_hold: instr/v/req=%h/%b/%b, required D800/1/0", instr_out, valid_out, bus.imem_req);
    end
    stall = 1'b0;
    tick();
    tick();
    tests++;
    if (halted !== 1'b1) begin
      fails++;
      $display("FAIL stall_halted: h=%b, required 1", halted);
    end
    end_task("stall");
  endtask
  task automatic test_redirect();
    start(3);
    mem[16'h0000] = 16'h4001;
    mem[16'h0100] = 16'h4100;
    expect_load(16'h0100, 16'h4100);
    expect_load(16'h0102, 16'h0000);
    release_rst();
    tick();
    redirect = 1'b1;
    redirect_pc = 16'h0101;
    tick();
    redirect = 1'b0;
    tick();
    tests++;
    if ({valid_out, bus.imem_req} !== {1'b0, 1'b0}) begin
      fails++;
      $display("FAIL redir_stale: v/req=%b/%b, required 0/0", valid_out, bus.imem_req);
    end
    tick();
    tests++;
    if ({bus.imem_req, bus.imem_addr, valid_out} !== {1'b1, 16'h0100, 1'b0}) begin
      fails++;
      $display("FAIL redir_refetch: req/addr/v=%b/%h/%b, required 1/0100/0", bus.imem_req, bus.imem_addr, valid_out);
    end
    repeat (4) tick();
    tests++;
    if ({instr_out, pc_next_out} !== {16'h4100, 16'h0102}) begin
      fails++;
      $display("FAIL redir_target: instr/pcn=%h/%h, required 4100/0102", instr_out, pc_next_out);
    end
    repeat (5) tick();
    end_task("redirect");
  endtask
  task automatic test_halt_resume();
    int n = 0;
    start(1);
    mem[16'h0040] = 16'h4040;
    expect_load(16'h0010, 16'h0000);
    expect_load(16'h0040, 16'h4040);
    expect_load(16'h0042, 16'h0000);
    release_rst();
    redirect = 1'b1;
    redirect_pc = 16'h0010;
    tick();
    redirect = 1'b0;
    tests++;
    if (bus.imem_addr !== 16'h0010) begin
      fails++;
      $display("FAIL halt_addr: addr=%h, required 0010", bus.imem_addr);
    end
    tick();
    tick();
    stall = 1'b1;
    tests++;
    if ({instr_out, halted} !== {16'h0000, 1'b0}) begin
      fails++;
      $display("FAIL halt_word: instr/h=%h/%b, required 0000/0", instr_out, halted);
    end
    repeat (20) begin
      tick();
      if (bus.imem_req) n++;
    end
    tests++;
    if ({n, halted, valid_out, instr_out} !== {32'd0, 1'b1, 1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL halt_stay: reqs/h/v/instr=%0d/%b/%b/%h, required 0/1/1/0000", n, halted, valid_out, instr_out);
    end
    redirect = 1'b1;
    redirect_pc = 16'h0040;
    tick();
    redirect = 1'b0;
    stall = 1'b0;
    tests++;
    if ({halted, valid_out, instr_out, bus.imem_addr} !== {1'b0, 1'b0, 16'h0800, 16'h0040}) begin
      fails++;
      $display("FAIL halt_resume: h/v/instr/addr=%b/%b/%h/%h, required 0/0/0800/0040",
               halted, valid_out, instr_out, bus.imem_addr);
    end
    repeat (6) tick();
    end_task("halt");
  endtask
  task automatic test_wrap();
    start(1);
    mem[16'hFFFE] = 16'h0800;
    expect_load(16'hFFFE, 16'h0800);
    expect_load(16'h0000, 16'h0000);
    release_rst();
    redirect = 1'b1;
    redirect_pc = 16'hFFFE;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    tests++;
    if ({instr_out, pc_out, pc_next_out, bus.imem_req, bus.imem_addr} !==
        {16'h0800, 16'hFFFE, 16'h0000, 1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL wrap: instr/pc/pcn/req/addr=%h/%h/%h/%b/%h, required 0800/FFFE/0000/1/0000",
               instr_out, pc_out, pc_next_out, bus.imem_req, bus.imem_addr);
    end
    repeat (4) tick();
    end_task("wrap");
  endtask
  task automatic test_rst_mid();
    start(3);
    mem[16'h0000] = 16'h4001;
    expect_load(16'h0000, 16'h4001);
    expect_load(16'h0000, 16'h4001);
    expect_load(16'h0002, 16'h0000);
    release_rst();
    repeat (5) tick();
    rst = 1'b1;
    #1;
    tests++;
    if ({instr_out, pc_out, pc_next_out, valid_out, halted, bus.imem_req, bus.imem_addr} !==
        {16'h0800, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
      fails++;
      $display("FAIL rst_mid_async: instr/pc/pcn/v/h/req/addr=%h/%h/%h/%b/%b/%b/%h, required 0800/0000/0000/0/0/0/0000",
               instr_out, pc_out, pc_next_out, valid_out, halted, bus.imem_req, bus.imem_addr);
    end
    tick();
    release_rst();
    tests++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b1, 16'h0000}) begin
      fails++;
      $display("FAIL rst_mid_restart: req/addr=%b/%h, required 1/0000", bus.imem_req, bus.imem_addr);
    end
    tick();
    tests++;
    if ({valid_out, bus.imem_req} !== {1'b0, 1'b0}) begin
      fails++;
      $display("FAIL rst_mid_late: v/req=%b/%b, required 0/0", valid_out, bus.imem_req);
    end
    repeat (8) tick();
    end_task("rst_mid");
  endtask
  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_redirect();
    test_halt_resume();
    test_wrap();
    test_rst_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
